// File: rtl/ysyx_23060203_pkg.sv
// Shared definitions for the ysyx_23060203 instruction-fetch path:
// opcode constants, the fetch-queue entry layout and immediate decoders.
package ysyx_23060203_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // One fetch-queue slot: where the word came from, the word, and
    // whether the fetch stage redirected after it (predicted taken).
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } fq_entry_t;

    // B-type immediate, sign-extended, bit 0 always zero.
    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    // J-type immediate, sign-extended, bit 0 always zero.
    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // Conditional branch major opcode; the low two bits are not decoded.
    function automatic logic is_branch(input logic [31:0] inst);
        logic [6:0] op;
        op = OP_BRANCH;
        return (inst[6:2] == op[6:2]);
    endfunction

endpackage

// File: rtl/ysyx_23060203_ifu_fifo.sv
// Circular fetch queue. Storage is reset to zero; a clear only rewinds
// the pointers so stale entries are never visible (count gates validity).
module ysyx_23060203_ifu_fifo
    import ysyx_23060203_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             enq,
    input  fq_entry_t        enq_data,
    input  logic             deq,
    output fq_entry_t        head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fq_entry_t        mem_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic             enq_ok_s;
    logic             deq_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign head_data = mem_r[head_r];

    // Refuse pushes into a full queue unless a pop frees the slot this cycle.
    always_comb begin
        enq_ok_s = enq & (~full | deq);
        deq_ok_s = deq & ~empty;
    end

    // Entry storage; written only at the tail on an accepted push.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {$bits(fq_entry_t){1'b0}};
            end
        end else if (enq_ok_s && !clr) begin
            mem_r[tail_r] <= enq_data;
        end else begin
            mem_r[tail_r] <= mem_r[tail_r];
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (enq_ok_s) begin
                tail_r <= tail_r + PTR_W'(1'b1);
            end else begin
                tail_r <= tail_r;
            end
            if (deq_ok_s) begin
                head_r <= head_r + PTR_W'(1'b1);
            end else begin
                head_r <= head_r;
            end
            case ({enq_ok_s, deq_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_23060203_ifu_fq.sv
// Instruction fetch unit with a small fetch queue and static branch
// prediction (backward conditional branches predicted taken).
// Optional feature macro: YSYX_23060203_IFU_JAL_PRED_EN -- when defined,
// JAL is also redirected at fetch time to its target.
module ysyx_23060203_ifu_fq
    import ysyx_23060203_pkg::*;
#(
    parameter int          FQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] ic_addr,
    input  logic        ic_hit,
    input  logic [31:0] ic_inst,
    input  logic        jump_flush,
    input  logic [31:0] jump_dnpc,
    input  logic        cs_flush,
    input  logic [31:0] cs_dnpc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_pred
);

    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

    logic [31:0]      fetch_pc_r;
    logic             flush_r;
    logic [31:0]      dnpc_r;

    logic             flush_s;
    logic [31:0]      dnpc_s;
    logic [31:0]      pred_pc_s;
    logic             pred_taken_s;
    logic             enq_s;
    logic             deq_s;
    fq_entry_t        enq_data_s;
    fq_entry_t        head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;

    // Redirect merge: a CSR/trap redirect outranks an EXU jump.
    always_comb begin
        flush_s = jump_flush | cs_flush;
        if (cs_flush) begin
            dnpc_s = cs_dnpc;
        end else begin
            dnpc_s = jump_dnpc;
        end
    end

    // Static next-pc prediction from the word arriving from the ICache.
    always_comb begin
        pred_taken_s = 1'b0;
        pred_pc_s    = fetch_pc_r + 32'd4;
        if (is_branch(ic_inst) && ic_inst[31]) begin
            pred_taken_s = 1'b1;
            pred_pc_s    = fetch_pc_r + imm_b(ic_inst);
        end
`ifdef YSYX_23060203_IFU_JAL_PRED_EN
        else if (ic_inst[6:0] == OP_JAL) begin
            pred_taken_s = 1'b1;
            pred_pc_s    = fetch_pc_r + imm_j(ic_inst);
        end
`endif
        else begin
            pred_taken_s = 1'b0;
            pred_pc_s    = fetch_pc_r + 32'd4;
        end
    end

    // Queue handshake: nothing moves in a redirect cycle, and nothing is
    // pushed while a redirect is still waiting for the refill to land.
    always_comb begin
        deq_s           = out_ready & ~fifo_empty_s & ~flush_s;
        enq_s           = ic_hit & ~flush_s & ~flush_r & (~fifo_full_s | deq_s);
        enq_data_s.pc   = fetch_pc_r;
        enq_data_s.inst = ic_inst;
        enq_data_s.pred = pred_taken_s;
    end

    // Fetch pointer and pending-redirect state.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
            flush_r    <= 1'b0;
            dnpc_r     <= 32'h0000_0000;
        end else if (flush_s) begin
            if (ic_hit) begin
                fetch_pc_r <= dnpc_s;
                flush_r    <= 1'b0;
                dnpc_r     <= dnpc_r;
            end else begin
                // ICache is mid-refill: keep its address stable until it
                // answers, then jump to the remembered target.
                fetch_pc_r <= fetch_pc_r;
                flush_r    <= 1'b1;
                dnpc_r     <= dnpc_s;
            end
        end else if (flush_r) begin
            if (ic_hit) begin
                fetch_pc_r <= dnpc_r;
                flush_r    <= 1'b0;
            end else begin
                fetch_pc_r <= fetch_pc_r;
                flush_r    <= 1'b1;
            end
        end else if (enq_s) begin
            fetch_pc_r <= pred_pc_s;
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    ysyx_23060203_ifu_fifo #(
        .DEPTH (FQ_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clr       (flush_s),
        .enq       (enq_s),
        .enq_data  (enq_data_s),
        .deq       (deq_s),
        .head_data (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign ic_addr   = fetch_pc_r;
    assign out_valid = (fifo_count_s != {CNT_W{1'b0}}) & ~flush_s;
    assign out_pc    = head_s.pc;
    assign out_inst  = head_s.inst;
    assign out_pred  = head_s.pred;

endmodule

// File: tb/tb_ysyx_23060203_ifu_fq.sv
// Scoreboard bench for ysyx_23060203_ifu_fq: directed stimulus pushes the
// expected queue entries, a negedge monitor pops them on each handshake.
module tb_ysyx_23060203_ifu_fq;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BEQ = 32'hFE00_0EE3;
    localparam logic [31:0] JAL = 32'h0100_006F;
`ifdef YSYX_23060203_IFU_JAL_PRED_EN
    localparam logic [31:0] JAL_NEXT = 32'h8000_0010;
    localparam logic        JAL_PRED = 1'b1;
`else
    localparam logic [31:0] JAL_NEXT = 32'h8000_0004;
    localparam logic        JAL_PRED = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ic_hit = 1'b0;
    logic [31:0] ic_inst;
    logic        jump_flush = 1'b0;
    logic [31:0] jump_dnpc = 32'h0;
    logic        cs_flush = 1'b0;
    logic [31:0] cs_dnpc = 32'h0;
    logic        out_ready = 1'b0;
    logic [31:0] ic_addr;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_pred;

    logic [31:0] sp_addr = 32'h0;
    logic [31:0] sp_inst = NOP;

    int errors = 0;
    int checks = 0;
    logic [64:0] exp_q[$];

    ysyx_23060203_ifu_fq dut (
        .clock      (clock),
        .reset      (reset),
        .ic_addr    (ic_addr),
        .ic_hit     (ic_hit),
        .ic_inst    (ic_inst),
        .jump_flush (jump_flush),
        .jump_dnpc  (jump_dnpc),
        .cs_flush   (cs_flush),
        .cs_dnpc    (cs_dnpc),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_inst   (out_inst),
        .out_pred   (out_pred)
    );

    always #5 clock = ~clock;

    // Instruction memory model: NOP everywhere except one planted word.
    always_comb ic_inst = (ic_addr == sp_addr) ? sp_inst : NOP;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic pred);
        exp_q.push_back({pc, inst, pred});
    endtask

    // Monitor: every accepted output must match the oldest expectation.
    always @(negedge clock) begin
        logic [64:0] e;
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL deq_unexpected: got pc=%h inst=%h, none expected", out_pc, out_inst);
            end else begin
                e = exp_q.pop_front();
                check32("deq_pc", out_pc, e[64:33]);
                check32("deq_inst", out_inst, e[32:1]);
                check32("deq_pred", {31'd0, out_pred}, {31'd0, e[0]});
            end
        end
    end

    // Advance one clock, apply new inputs just after the edge, stop at negedge.
    task automatic cyc(input logic hit, input logic rdy, input logic jf, input logic cf);
        @(posedge clock);
        #1;
        ic_hit = hit;
        out_ready = rdy;
        jump_flush = jf;
        cs_flush = cf;
        @(negedge clock);
    endtask

    // Reset with a simultaneous hit and flush, which reset must override.
    task automatic do_reset(input string name);
        reset = 1'b1;
        ic_hit = 1'b1;
        jump_flush = 1'b1;
        jump_dnpc = 32'h1234_5678;
        out_ready = 1'b1;
        sp_addr = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        ic_hit = 1'b0;
        jump_flush = 1'b0;
        cs_flush = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        @(negedge clock);
        check32({name, "_rst_addr"}, ic_addr, 32'h8000_0000);
        check32({name, "_rst_valid"}, {31'd0, out_valid}, 32'd0);
        check32({name, "_rst_pc"}, out_pc, 32'd0);
        check32({name, "_rst_inst"}, out_inst, 32'd0);
        check32({name, "_rst_pred"}, {31'd0, out_pred}, 32'd0);
    endtask

    // Count remaining valid outputs with fetch idle; bounded.
    task automatic drain(input int exp_n, input string name);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (out_valid !== 1'b1) break;
            n++;
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
        end
        check32({name, "_drain"}, n, exp_n);
        check32({name, "_sb_empty"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Streaming NOPs: one word per cycle after a one-cycle latency.
        do_reset("t1");
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check32("t1_first_valid", {31'd0, out_valid}, 32'd0);
        check32("t1_first_addr", ic_addr, 32'h8000_0000);
        push(32'h8000_0000, NOP, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            check32("t1_stream_valid", {31'd0, out_valid}, 32'd1);
            push(32'h8000_0000 + 32'(k * 4), NOP, 1'b0);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        drain(1, "t1");
        check32("t1_end_addr", ic_addr, 32'h8000_0014);

        // Back-pressure fills the queue, then push+pop at full.
        do_reset("t2");
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            push(32'h8000_0000 + 32'(k * 4), NOP, 1'b0);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check32("t2_full_addr", ic_addr, 32'h8000_0010);
        check32("t2_full_valid", {31'd0, out_valid}, 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        push(32'h8000_0010, NOP, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check32("t2_fullswap_addr", ic_addr, 32'h8000_0014);
        push(32'h8000_0014, NOP, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        drain(4, "t2");
        check32("t2_end_addr", ic_addr, 32'h8000_0018);

        // Backward branch predicted taken.
        do_reset("t3");
        sp_addr = 32'h8000_0008;
        sp_inst = BEQ;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        push(32'h8000_0000, NOP, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        push(32'h8000_0004, NOP, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check32("t3_beq_fetch", ic_addr, 32'h8000_0008);
        push(32'h8000_0008, BEQ, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check32("t3_pred_addr", ic_addr, 32'h8000_0004);
        check32("t3_head_pc", out_pc, 32'h8000_0008);
        check32("t3_head_pred", {31'd0, out_pred}, 32'd1);
        push(32'h8000_0004, NOP, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        drain(1, "t3");
        sp_addr = 32'h0;

        // Jump flush during an ICache miss.
        do_reset("t4");
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        push(32'h8000_0000, NOP, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        push(32'h8000_0004, NOP, 1'b0);
        jump_dnpc = 32'h8000_0100;
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        check32("t4_flush_valid", {31'd0, out_valid}, 32'd0);
        exp_q.delete();
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check32("t4_miss1_valid", {31'd0, out_valid}, 32'd0);
        check32("t4_miss1_addr", ic_addr, 32'h8000_0008);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check32("t4_miss2_valid", {31'd0, out_valid}, 32'd0);
        check32("t4_miss2_addr", ic_addr, 32'h8000_0008);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check32("t4_refill_valid", {31'd0, out_valid}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check32("t4_redir_addr", ic_addr, 32'h8000_0100);
        check32("t4_redir_valid", {31'd0, out_valid}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        push(32'h8000_0100, NOP, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        drain(1, "t4");

        // Simultaneous flushes: CSR target wins; then a re-flush while pending.
        do_reset("t5");
        jump_dnpc = 32'h8000_0100;
        cs_dnpc = 32'h8000_0200;
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        check32("t5_flush_valid", {31'd0, out_valid}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check32("t5_cs_prio_addr", ic_addr, 32'h8000_0200);
        push(32'h8000_0200, NOP, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        drain(1, "t5a");
        jump_dnpc = 32'h8000_0300;
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cs_dnpc = 32'h8000_0400;
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check32("t5_pending_addr", ic_addr, 32'h8000_0204);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check32("t5_reflush_addr", ic_addr, 32'h8000_0400);
        check32("t5_reflush_valid", {31'd0, out_valid}, 32'd0);

        // JAL at reset pc.
        do_reset("t6");
        sp_addr = 32'h8000_0000;
        sp_inst = JAL;
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        push(32'h8000_0000, JAL, JAL_PRED);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check32("t6_jal_addr", ic_addr, JAL_NEXT);
        drain(1, "t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_23060203_ifu_fq.md
YSYX_23060203_IFU_FQ -- requirements
Module: ysyx_23060203_ifu_fq

Interface
REQ-001 SHALL have parameter FQ_DEPTH, default 4, fetch-queue entries; power of two, 2..16.
REQ-002 SHALL have parameter RESET_PC, default 32'h80000000, first fetch address.
REQ-003 SHALL have port clock, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ic_addr, output, 32, fetch address to ICache (equals fetch_pc register).
REQ-006 SHALL have port ic_hit, input, 1, ICache holds the word at ic_addr this cycle.
REQ-007 SHALL have port ic_inst, input, 32, instruction word at ic_addr, valid when ic_hit.
REQ-008 SHALL have ports jump_flush, input, 1, and jump_dnpc, input, 32: EXU redirect.
REQ-009 SHALL have ports cs_flush, input, 1, and cs_dnpc, input, 32: CSR/trap redirect.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts.
REQ-011 SHALL have port out_valid, output, 1, queue head valid.
REQ-012 SHALL have ports out_pc, output, 32, out_inst, output, 32, out_pred, output, 1: head pc, word, predicted-taken flag.

Function
REQ-013 SHALL treat flush = jump_flush | cs_flush; cs_flush SHALL take priority, dnpc = cs_flush ? cs_dnpc : jump_dnpc.
REQ-014 SHALL compute next-pc prediction from ic_inst: B-type (opcode[6:2]=11000) with inst[31]=1 -> fetch_pc+imm_b, pred=1; otherwise fetch_pc+4, pred=0; all sums modulo 2^32.
REQ-015 SHALL enqueue {fetch_pc, ic_inst, pred} and advance fetch_pc to predicted pc when ic_hit & ~flush & ~flush_r & (count<FQ_DEPTH | deq).
REQ-016 SHALL dequeue when out_valid & out_ready; enqueue and dequeue in one cycle SHALL leave count unchanged, including at full.
REQ-017 SHALL drive out_valid = (count!=0) & ~flush combinationally; out_pc/out_inst/out_pred SHALL come from head entry.
REQ-018 SHALL deliver a word fetched on hit in cycle N as out_valid in cycle N+1 when queue empty (1-cycle latency).
REQ-019 SHALL on flush empty the queue (count, head, tail to 0) on the same edge, no enqueue that cycle.
REQ-020 SHALL on flush with ic_hit load fetch_pc <= dnpc; without ic_hit set flush_r=1, dnpc_r <= dnpc (lets in-progress refill complete).
REQ-021 SHALL while flush_r=1 suppress enqueue; on ic_hit load fetch_pc <= dnpc_r, clear flush_r.
REQ-022 SHALL on new flush while flush_r=1 use the new dnpc, overwriting dnpc_r.
REQ-023 SHALL hold ic_addr stable while ~ic_hit except on flush-redirect.
REQ-024 SHALL wrap head/tail pointers modulo FQ_DEPTH; count width clog2(FQ_DEPTH)+1.

Reset
REQ-025 SHALL on reset set fetch_pc=RESET_PC, count/head/tail=0, flush_r=0, dnpc_r=0, all queue entries 0.
REQ-026 SHALL hold out_valid=0, out_pc=0, out_inst=0, out_pred=0 in the cycle after reset; reset SHALL override simultaneous flush/hit.

Configuration
REQ-027 SHALL with YSYX_23060203_IFU_JAL_PRED_EN defined predict JAL (opcode 1101111) as fetch_pc+imm_j, pred=1.
REQ-028 SHALL without YSYX_23060203_IFU_JAL_PRED_EN treat JAL as fetch_pc+4, pred=0; no other behaviour changes.

Structure
REQ-029 SHALL place opcode constants (OP_BRANCH, OP_JAL), queue-entry struct typedef (pc, inst, pred), and imm_b/imm_j extraction functions in shared package ysyx_23060203_pkg.
REQ-030 SHALL implement queue storage/pointers in sub-module ysyx_23060203_ifu_fifo (parameter DEPTH, enq/deq/clr, full/empty/count).
REQ-031 SHALL keep fetch_pc, flush_r, dnpc_r, prediction logic in top module.

Verification
REQ-032 SHALL cover: reset, ic_hit=1 always, out_ready=1, ic_inst=NOP -> out_pc 0x80000000, 0x80000004, 0x80000008 on consecutive cycles from cycle 2.
REQ-033 SHALL cover: out_ready=0, ic_hit=1 -> count saturates at 4, ic_addr stops at 0x80000010; out_ready=1 with full queue -> enq+deq same cycle, count stays 4.
REQ-034 SHALL cover: ic_inst=0xFE000EE3 (beq x0,x0,-4) at 0x80000008 -> next ic_addr 0x80000004, out_pred=1.
REQ-035 SHALL cover: jump_flush=1, jump_dnpc=0x80000100, ic_hit=0 for 3 cycles then 1 -> out_valid=0 throughout, ic_addr=0x80000100 after hit, queue empty.
REQ-036 SHALL cover: jump_flush and cs_flush same cycle (0x80000100 / 0x80000200) -> fetch resumes at 0x80000200.
REQ-037 SHALL cover: JAL 0x0100006F at 0x80000000 -> next ic_addr 0x80000010 with macro, 0x80000004 without.
